// File: rtl/pc_module_if.sv
// Fetch-stage PC bus: next-PC/redirect/stall controls in, registered PC state out.
interface pc_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC_Next;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_Plus4;
  logic            PC_Valid;
  logic            misalign_err;

  // master: next-PC logic / pipeline control; slave: the PC register itself
  modport master (
    output PC_Next, stall, redirect_valid, redirect_pc,
    input  PC, PC_Plus4, PC_Valid, misalign_err
  );

  modport slave (
    input  PC_Next, stall, redirect_valid, redirect_pc,
    output PC, PC_Plus4, PC_Valid, misalign_err
  );
endinterface

// File: rtl/pc_module.sv
// Fetch-stage program counter; new address visible on PC one edge after it is presented.
// Priority rst > redirect > stall (hold) > PC_Next; no backpressure beyond the stall hold.
module pc_module #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  // Reset target is aligned the same way as every other load.
  localparam logic [XLEN-1:0] RESET_ALIGNED = {RESET_VECTOR[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_misalign;

  logic [XLEN-1:0] w_src;
  logic            w_load;

  always_comb begin
    w_src  = bus.PC_Next;
    w_load = 1'b1;
    if (bus.redirect_valid) begin
      w_src = bus.redirect_pc;
    end else if (bus.stall) begin
      w_src  = r_pc;
      w_load = 1'b0;
    end
  end

  // A hold edge never reports misalignment, even if the held PC came from a misaligned source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_ALIGNED;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= {w_src[XLEN-1:2], 2'b00};
      r_pc_valid <= 1'b1;
      r_misalign <= w_load && (w_src[1:0] != 2'b00);
    end
  end

  assign bus.PC           = r_pc;
  assign bus.PC_Plus4     = r_pc + XLEN'(4);
  assign bus.PC_Valid     = r_pc_valid;
  assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_module.sv
// Directed-vector bench for pc_module: reset, sequential load, stall, redirect, alignment, wrap.
module tb_pc_module;
  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  pc_if #(.XLEN(32)) bus ();

  pc_module #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.PC_Next = 32'h0; bus.stall = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    step();
    tests_run++; if (bus.PC !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", bus.PC, 32'h0); end
    tests_run++; if (bus.PC_Plus4 !== 32'h4) begin tests_failed++; $display("FAIL reset_plus4: got %h want %h", bus.PC_Plus4, 32'h4); end
    tests_run++; if (bus.PC_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.PC_Valid); end
    tests_run++; if (bus.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %b want 0", bus.misalign_err); end
  endtask

  task automatic test_sequential();
    rst = 1'b0; bus.PC_Next = 32'h4;
    step();
    tests_run++; if (bus.PC !== 32'h4) begin tests_failed++; $display("FAIL seq_pc4: got %h want %h", bus.PC, 32'h4); end
    tests_run++; if (bus.PC_Plus4 !== 32'h8) begin tests_failed++; $display("FAIL seq_plus4_8: got %h want %h", bus.PC_Plus4, 32'h8); end
    tests_run++; if (bus.PC_Valid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid: got %b want 1", bus.PC_Valid); end
    bus.PC_Next = 32'h8;
    step();
    tests_run++; if (bus.PC !== 32'h8) begin tests_failed++; $display("FAIL seq_pc8: got %h want %h", bus.PC, 32'h8); end
    tests_run++; if (bus.PC_Plus4 !== 32'hC) begin tests_failed++; $display("FAIL seq_plus4_12: got %h want %h", bus.PC_Plus4, 32'hC); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.PC_Next = 32'h10;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++; if (bus.PC !== 32'h8) begin tests_failed++; $display("FAIL stall_hold_%0d: got %h want %h", k, bus.PC, 32'h8); end
    end
    bus.stall = 1'b0;
    step();
    tests_run++; if (bus.PC !== 32'h10) begin tests_failed++; $display("FAIL stall_release: got %h want %h", bus.PC, 32'h10); end
    tests_run++; if (bus.PC_Valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid: got %b want 1", bus.PC_Valid); end
  endtask

  task automatic test_redirect_over_stall();
    bus.stall = 1'b1; bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100; bus.PC_Next = 32'h20;
    step();
    tests_run++; if (bus.PC !== 32'h100) begin tests_failed++; $display("FAIL redir_stall_pc: got %h want %h", bus.PC, 32'h100); end
    tests_run++; if (bus.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL redir_stall_misalign: got %b want 0", bus.misalign_err); end
    bus.stall = 1'b0; bus.redirect_pc = 32'h203;
    step();
    tests_run++; if (bus.PC !== 32'h200) begin tests_failed++; $display("FAIL redir_misalign_pc: got %h want %h", bus.PC, 32'h200); end
    tests_run++; if (bus.misalign_err !== 1'b1) begin tests_failed++; $display("FAIL redir_misalign_flag: got %b want 1", bus.misalign_err); end
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_misalign();
    bus.PC_Next = 32'h13;
    step();
    tests_run++; if (bus.PC !== 32'h10) begin tests_failed++; $display("FAIL mis_pc: got %h want %h", bus.PC, 32'h10); end
    tests_run++; if (bus.misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_flag: got %b want 1", bus.misalign_err); end
    bus.PC_Next = 32'h14;
    step();
    tests_run++; if (bus.PC !== 32'h14) begin tests_failed++; $display("FAIL mis_clear_pc: got %h want %h", bus.PC, 32'h14); end
    tests_run++; if (bus.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL mis_clear_flag: got %b want 0", bus.misalign_err); end
    bus.PC_Next = 32'h1B;
    step();
    tests_run++; if (bus.misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_again_flag: got %b want 1", bus.misalign_err); end
    bus.stall = 1'b1; bus.PC_Next = 32'h33;
    step();
    tests_run++; if (bus.PC !== 32'h18) begin tests_failed++; $display("FAIL mis_hold_pc: got %h want %h", bus.PC, 32'h18); end
    tests_run++; if (bus.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL mis_hold_flag: got %b want 0", bus.misalign_err); end
    bus.stall = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    bus.PC_Next = 32'hFFFF_FFFC;
    step();
    tests_run++; if (bus.PC !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc: got %h want %h", bus.PC, 32'hFFFF_FFFC); end
    tests_run++; if (bus.PC_Plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_plus4: got %h want %h", bus.PC_Plus4, 32'h0); end
    rst = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h400; bus.PC_Next = 32'h501;
    step();
    tests_run++; if (bus.PC !== 32'h0) begin tests_failed++; $display("FAIL midrst_pc: got %h want %h", bus.PC, 32'h0); end
    tests_run++; if (bus.PC_Valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b want 0", bus.PC_Valid); end
    tests_run++; if (bus.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_misalign: got %b want 0", bus.misalign_err); end
    tests_run++; if (bus.PC_Plus4 !== 32'h4) begin tests_failed++; $display("FAIL midrst_plus4: got %h want %h", bus.PC_Plus4, 32'h4); end
    rst = 1'b0; bus.redirect_valid = 1'b0; bus.PC_Next = 32'h40;
    step();
    tests_run++; if (bus.PC !== 32'h40) begin tests_failed++; $display("FAIL postrst_pc: got %h want %h", bus.PC, 32'h40); end
    tests_run++; if (bus.PC_Valid !== 1'b1) begin tests_failed++; $display("FAIL postrst_valid: got %b want 1", bus.PC_Valid); end
  endtask

  initial begin
    rst = 1'b1;
    bus.PC_Next = 32'h0; bus.stall = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_over_stall();
    test_misalign();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
